// File: rtl/traffic_ctrl_param_if.sv
// Signal bundle between the intersection controller and its surroundings:
// timing strobe and debounced requests in, lamp drives and status out.
interface traffic_ctrl_param_if;
    logic       tick_en;
    logic       walk_req;
    logic       sensor;
    logic       flash_mode;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;
    logic       walk_pending;
    logic [2:0] phase;

    modport master (
        output tick_en, walk_req, sensor, flash_mode,
        input  main_light, side_light, walk_light, walk_pending, phase
    );

    modport slave (
        input  tick_en, walk_req, sensor, flash_mode,
        output main_light, side_light, walk_light, walk_pending, phase
    );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Parametrised main/side intersection controller with latched pedestrian
// request and a flashing night mode; all timing advances on tick_en only.
module traffic_ctrl_param #(
    parameter int CW      = 4,
    parameter int T_GRN   = 6,
    parameter int T_EXT_S = 3,
    parameter int T_EXT_L = 6,
    parameter int T_YEL   = 2,
    parameter int T_WALK  = 3
) (
    input  logic                 clk,
    input  logic                 btn_rst,
    traffic_ctrl_param_if.slave  bus
);
    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_EXT = 3'd1,
        MAIN_YEL = 3'd2,
        WALK     = 3'd3,
        SIDE_GRN = 3'd4,
        SIDE_EXT = 3'd5,
        SIDE_YEL = 3'd6,
        FLASH    = 3'd7
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [CW-1:0]  ext_len_reg, ext_len_next;
    logic           pend_reg, pend_next;
    logic           fph_reg, fph_next;
    logic [CW-1:0]  limit;
    logic           last_tick;

    always_ff @(posedge clk or posedge btn_rst) begin
        if (btn_rst) begin
            state_reg   <= MAIN_GRN;
            cnt_reg     <= '0;
            ext_len_reg <= CW'(T_EXT_L);
            pend_reg    <= 1'b0;
            fph_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ext_len_reg <= ext_len_next;
            pend_reg    <= pend_next;
            fph_reg     <= fph_next;
        end
    end

    // Main-road extension length was latched when MAIN_GRN ended.
    always_comb begin
        limit = CW'(1);
        case (state_reg)
            MAIN_GRN, SIDE_GRN: limit = CW'(T_GRN);
            MAIN_EXT:           limit = ext_len_reg;
            SIDE_EXT:           limit = CW'(T_EXT_S);
            MAIN_YEL, SIDE_YEL: limit = CW'(T_YEL);
            WALK:               limit = CW'(T_WALK);
            default:            limit = CW'(1);
        endcase
    end

    assign last_tick = (cnt_reg == limit - CW'(1));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ext_len_next = ext_len_reg;
        fph_next     = fph_reg;
        if (bus.tick_en) begin
            if (state_reg == FLASH) begin
                if (!bus.flash_mode) begin
                    state_next = MAIN_GRN;
                    cnt_next   = '0;
                    fph_next   = 1'b0;
                end else begin
                    fph_next   = ~fph_reg;
                end
            end else if (last_tick) begin
                cnt_next = '0;
                case (state_reg)
                    MAIN_GRN: begin
                        state_next   = MAIN_EXT;
                        ext_len_next = bus.sensor ? CW'(T_EXT_S) : CW'(T_EXT_L);
                    end
                    MAIN_EXT: state_next = MAIN_YEL;
                    MAIN_YEL: state_next = pend_reg ? WALK : SIDE_GRN;
                    WALK:     state_next = SIDE_GRN;
                    SIDE_GRN: state_next = bus.sensor ? SIDE_EXT : SIDE_YEL;
                    SIDE_EXT: state_next = SIDE_YEL;
                    SIDE_YEL: state_next = bus.flash_mode ? FLASH : MAIN_GRN;
                    default:  state_next = MAIN_GRN;
                endcase
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Serving the request on WALK entry overrides a same-edge new request.
    always_comb begin
        pend_next = pend_reg | bus.walk_req;
        if (state_next == WALK && state_reg != WALK)
            pend_next = 1'b0;
    end

    always_comb begin
        bus.main_light = 3'b100;
        bus.side_light = 3'b100;
        bus.walk_light = 1'b0;
        case (state_reg)
            MAIN_GRN, MAIN_EXT: bus.main_light = 3'b001;
            MAIN_YEL:           bus.main_light = 3'b010;
            SIDE_GRN, SIDE_EXT: bus.side_light = 3'b001;
            SIDE_YEL:           bus.side_light = 3'b010;
            WALK:               bus.walk_light = 1'b1;
            FLASH: begin
                bus.main_light = fph_reg ? 3'b010 : 3'b000;
                bus.side_light = fph_reg ? 3'b100 : 3'b000;
            end
            default: begin
                bus.main_light = 3'b100;
                bus.side_light = 3'b100;
            end
        endcase
    end

    assign bus.walk_pending = pend_reg;
    assign bus.phase        = state_reg;
endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: directed phase-timing scenarios plus random
// stimulus, all checked against a countdown-based behavioural model.
module tb_traffic_ctrl_param;
    localparam int T_GRN = 6, T_EXT_S = 3, T_EXT_L = 6, T_YEL = 2, T_WALK = 3;

    logic clk = 1'b0;
    logic btn_rst = 1'b1;
    logic tick_en = 1'b0, walk_req = 1'b0, sensor = 1'b0, flash_mode = 1'b0;
    logic g_req = 1'b0, g_sens = 1'b0, g_fm = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    traffic_ctrl_param_if bus1();
    traffic_ctrl_param_if bus2();

    assign bus1.tick_en = tick_en;  assign bus2.tick_en = tick_en;
    assign bus1.walk_req = walk_req; assign bus2.walk_req = walk_req;
    assign bus1.sensor = sensor;    assign bus2.sensor = sensor;
    assign bus1.flash_mode = flash_mode; assign bus2.flash_mode = flash_mode;

    traffic_ctrl_param u_dut (.clk(clk), .btn_rst(btn_rst), .bus(bus1));

    traffic_ctrl_param #(.CW(3), .T_GRN(6), .T_EXT_S(3), .T_EXT_L(6), .T_YEL(1), .T_WALK(3))
        u_dut_y1 (.clk(clk), .btn_rst(btn_rst), .bus(bus2));

    always #5 clk = ~clk;

    // Model: current phase, ticks remaining in it, pending flag, flash phase.
    int m_phase, m_left, m_pend, m_fph;

    task automatic model_reset();
        m_phase = 0; m_left = T_GRN; m_pend = 0; m_fph = 0;
    endtask

    function automatic int dur(int p, logic s);
        case (p)
            0, 4:    return T_GRN;
            1:       return s ? T_EXT_S : T_EXT_L;
            2, 6:    return T_YEL;
            3:       return T_WALK;
            5:       return T_EXT_S;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(logic tk, logic rq, logic sn, logic fm);
        int nxt;
        logic served;
        served = 1'b0;
        nxt = m_phase;
        if (btn_rst) return;
        if (tk) begin
            if (m_phase == 7) begin
                if (!fm) begin m_phase = 0; m_left = T_GRN; m_fph = 0; end
                else m_fph = !m_fph;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    case (m_phase)
                        0: nxt = 1;
                        1: nxt = 2;
                        2: nxt = m_pend ? 3 : 4;
                        3: nxt = 4;
                        4: nxt = sn ? 5 : 6;
                        5: nxt = 6;
                        6: nxt = fm ? 7 : 0;
                        default: nxt = 0;
                    endcase
                    served = (nxt == 3);
                    m_phase = nxt;
                    m_left = dur(nxt, sn);
                end
            end
        end
        m_pend = served ? 0 : (m_pend | int'(rq));
    endtask

    function automatic int exp_main(int p, int f);
        case (p)
            0, 1:    return 1;
            2:       return 2;
            7:       return f ? 2 : 0;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_side(int p, int f);
        case (p)
            4, 5:    return 1;
            6:       return 2;
            7:       return f ? 4 : 0;
            default: return 4;
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always begin
        @(posedge clk);
        #1;
        chk("phase", int'(bus1.phase), m_phase);
        chk("main_light", int'(bus1.main_light), exp_main(m_phase, m_fph));
        chk("side_light", int'(bus1.side_light), exp_side(m_phase, m_fph));
        chk("walk_light", int'(bus1.walk_light), int'(m_phase == 3));
        chk("walk_pending", int'(bus1.walk_pending), m_pend);
    end

    // Phase-duration log per DUT: entries are phase*100 + ticks spent.
    int q1[$], q2[$];
    int last1 = 0, cur1 = 0, last2 = 0, cur2 = 0;
    always begin
        @(posedge clk);
        #1;
        if (btn_rst) begin
            last1 = 0; cur1 = 0; last2 = 0; cur2 = 0;
        end else begin
            if (tick_en) begin cur1++; cur2++; end
            if (int'(bus1.phase) != last1) begin
                q1.push_back(last1 * 100 + cur1); cur1 = 0; last1 = int'(bus1.phase);
            end
            if (int'(bus2.phase) != last2) begin
                q2.push_back(last2 * 100 + cur2); cur2 = 0; last2 = int'(bus2.phase);
            end
        end
    end

    task automatic cyc(logic tk);
        @(negedge clk);
        tick_en = tk; walk_req = g_req; sensor = g_sens; flash_mode = g_fm;
        model_step(tk, g_req, g_sens, g_fm);
        @(posedge clk);
        #2;
    endtask

    task automatic tick4();
        cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    endtask

    task automatic run_ticks(int n);
        for (int i = 0; i < n; i++) tick4();
    endtask

    task automatic run_until(int p, int max_ticks, string name);
        int k;
        k = 0;
        while (int'(bus1.phase) != p && k < max_ticks) begin tick4(); k++; end
        chk(name, int'(bus1.phase), p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_rst = 1'b1; tick_en = 1'b0; walk_req = 1'b0;
        g_req = 1'b0;
        model_reset();
        #1;
        chk("rst_phase", int'(bus1.phase), 0);
        chk("rst_main", int'(bus1.main_light), 1);
        chk("rst_side", int'(bus1.side_light), 4);
        chk("rst_walk", int'(bus1.walk_light), 0);
        chk("rst_pending", int'(bus1.walk_pending), 0);
        @(negedge clk);
        @(negedge clk);
        btn_rst = 1'b0;
        q1.delete(); q2.delete();
    endtask

    task automatic chk_q(string name, input int q[$], input int e[6], input int n);
        chk({name, "_len"}, int'(q.size() >= n), 1);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), (i < q.size()) ? q[i] : -1, e[i]);
    endtask

    initial begin
        int e[6];
        model_reset();
        @(negedge clk);
        @(negedge clk);
        btn_rst = 1'b0;

        // Idle cycle: 0(6),1(6),2(2),4(6),6(2); short-yellow variant 2(1),6(1).
        do_reset();
        g_sens = 0; g_fm = 0;
        run_ticks(25);
        e = '{6, 106, 202, 406, 602, 0};   chk_q("idle", q1, e, 5);
        e = '{6, 106, 201, 406, 601, 0};   chk_q("idle_y1", q2, e, 5);

        // Sensor held: 6,3,2,6,3,2.
        do_reset();
        g_sens = 1;
        run_ticks(23);
        e = '{6, 103, 202, 406, 503, 602}; chk_q("sensor", q1, e, 6);

        // Walk request pulse after tick 3.
        do_reset();
        g_sens = 0;
        run_ticks(3);
        g_req = 1; cyc(1'b0); g_req = 0;
        chk("walk_latched", int'(bus1.walk_pending), 1);
        run_ticks(23);
        e = '{6, 106, 202, 303, 406, 602}; chk_q("walk", q1, e, 6);

        // Request held through WALK entry: clear wins, then re-arms.
        do_reset();
        g_req = 1;
        for (int k = 0; k < 80 && int'(bus1.phase) != 3; k++) cyc(k % 4 == 3);
        chk("walk_entry_phase", int'(bus1.phase), 3);
        chk("walk_clear_wins", int'(bus1.walk_pending), 0);
        cyc(1'b0);
        chk("walk_rearm", int'(bus1.walk_pending), 1);
        g_req = 0;

        // Flash requested early: waits for SIDE_YEL exit, alternates, drops out.
        do_reset();
        g_fm = 1;
        run_until(7, 30, "flash_enter");
        e = '{6, 106, 202, 406, 602, 0};   chk_q("flash_seq", q1, e, 5);
        chk("flash_main0", int'(bus1.main_light), 0);
        tick4();
        chk("flash_main1", int'(bus1.main_light), 2);
        chk("flash_side1", int'(bus1.side_light), 4);
        tick4();
        chk("flash_main2", int'(bus1.main_light), 0);
        g_fm = 0;
        tick4();
        chk("flash_exit", int'(bus1.phase), 0);
        chk("flash_exit_main", int'(bus1.main_light), 1);

        // Reset mid SIDE_EXT with a pending request.
        do_reset();
        g_sens = 1;
        run_until(5, 40, "side_ext_reach");
        g_req = 1; cyc(1'b0); g_req = 0;
        chk("pend_before_rst", int'(bus1.walk_pending), 1);
        do_reset();
        g_sens = 0;
        run_ticks(6);
        e = '{6, 0, 0, 0, 0, 0};           chk_q("post_rst", q1, e, 1);

        // No ticks for 100 clocks: nothing moves.
        run_ticks(2);
        for (int k = 0; k < 100; k++) cyc(1'b0);
        chk("hold_phase", int'(bus1.phase), 1);

        // Randomised traffic.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) g_sens = ~g_sens;
            if ($urandom_range(0, 299) == 0) g_fm = ~g_fm;
            g_req = ($urandom_range(0, 19) == 0);
            if (k == 2000) do_reset();
            cyc($urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
Parametrised next-generation intersection controller for the main/side road lights. All phase durations are parameters. Timing comes from a one-cycle tick_en strobe (typically the 1 s divider output) in the single clk domain. Adds a latched pedestrian request with a status output and a safe-entry flashing (night) mode. Sits between the debounced button/sensor inputs and the light drivers.

Parameters:
CW, 4, width of the per-phase tick counter
T_GRN, 6, base green ticks (main and side)
T_EXT_S, 3, extension ticks when sensor=1
T_EXT_L, 6, extension ticks when sensor=0 (main road only)
T_YEL, 2, yellow ticks (main and side)
T_WALK, 3, all-red walk ticks
(Every T_* must be >=1 and <=2^CW-1.)

Ports:
clk  in  1  system clock
btn_rst  in  1  asynchronous reset, active-high
tick_en  in  1  one-clk-wide timing strobe; only clk edges with tick_en=1 advance timing
walk_req  in  1  debounced pedestrian request (level or pulse)
sensor  in  1  side-road vehicle sensor
flash_mode  in  1  request for flashing mode
main_light  out  3  {red,yellow,green}, one-hot except when dark in FLASH
side_light  out  3  {red,yellow,green}
walk_light  out  1  pedestrian walk lamp
walk_pending  out  1  latched request not yet served
phase  out  3  current state encoding, for debug

Behaviour:
- Reset: btn_rst=1 forces state=MAIN_GRN, cnt=0, walk_pending=0, flash_ph=0 immediately. Outputs: main=001, side=100, walk_light=0, phase=0. Reset mid-phase aborts the phase with no lamp glitch beyond the async state change.
- Fully synchronous apart from btn_rst. Outputs decode from registered state and flash_ph only; inputs have no combinational path to outputs.
- States and encodings: MAIN_GRN=0, MAIN_EXT=1, MAIN_YEL=2, WALK=3, SIDE_GRN=4, SIDE_EXT=5, SIDE_YEL=6, FLASH=7.
- Timer: cnt clears to 0 on entry to each state. On tick_en, if cnt==T_state-1 the state advances and cnt clears; otherwise cnt increments. Each state therefore lasts exactly T_state ticks. No change occurs on clk edges without tick_en.
- MAIN_GRN (T_GRN): exits to MAIN_EXT. sensor is sampled on the exit tick and selects the extension length, T_EXT_S if sensor=1 or T_EXT_L if sensor=0; the choice is held in a register.
- MAIN_EXT: exits to MAIN_YEL.
- MAIN_YEL (T_YEL): exits to WALK if walk_pending=1 on the exit tick, else to SIDE_GRN.
- WALK (T_WALK): main=100, side=100, walk_light=1. Exits to SIDE_GRN.
- SIDE_GRN (T_GRN): exits to SIDE_EXT (T_EXT_S) if sensor=1 on the exit tick, else to SIDE_YEL.
- SIDE_EXT: exits to SIDE_YEL.
- SIDE_YEL (T_YEL): exits to FLASH if flash_mode=1 on the exit tick, else to MAIN_GRN. FLASH is entered only from SIDE_YEL; flash_mode asserted elsewhere waits.
- FLASH: flash_ph toggles every tick_en. main=010 when flash_ph=1, 000 otherwise. side=100 when flash_ph=1, 000 otherwise. walk_light=0. On a tick with flash_mode=0, go to MAIN_GRN with cnt=0 and flash_ph=0. walk_pending is retained but not served.
- Lamp decode outside FLASH and WALK:
  - main: 001 in MAIN_GRN/EXT, 010 in MAIN_YEL, 100 elsewhere.
  - side: 001 in SIDE_GRN/EXT, 010 in SIDE_YEL, 100 elsewhere.
  - Main and side are never both non-red.
- walk_pending: set on any clk edge with walk_req=1; cleared on the edge entering WALK. If set and clear happen on the same edge, clear wins (the request is served). A request arriving during WALK re-arms for the next cycle.
- Counter never wraps. An illegal state recovers to MAIN_GRN on the next clk.

Test Plan:
- Reset and idle (tick_en every 4 clk, sensor=0, walk_req=0, flash_mode=0) -> phase sequence 0(6 ticks),1(6),2(2),4(6),6(2),0; period 22 ticks. main=001 for 12 ticks, then 010 for 2, then 100 for 8.
- sensor=1 throughout -> durations 6,3,2,6,3,2 (22 ticks), phases 0,1,2,4,5,6. side=001 for 9 ticks.
- walk_req pulse at tick 3 -> walk_pending=1 next clk. After MAIN_YEL: phase 3 for 3 ticks with main=side=100 and walk_light=1, walk_pending=0, then phase 4. Pulse coincident with the WALK-entry edge -> walk_pending stays 0.
- flash_mode=1 raised during MAIN_GRN -> no effect until the SIDE_YEL exit, then phase 7. Lamps alternate main 010/000 and side 100/000 each tick. Drop flash_mode -> phase 0 with cnt=0 on the next tick.
- btn_rst pulse mid-SIDE_EXT with walk_pending=1 -> immediately phase 0, main=001, side=100, walk_pending=0. Next 6 ticks stay in MAIN_GRN.
- tick_en held low for 100 clk in any state -> phase, cnt and lamps unchanged. Override T_YEL=1 and CW=3 -> yellow lasts exactly 1 tick.
